// File: rtl/cnt_pkg.sv
// Shared types and seven-segment decode for the cnt_bcd_mmss counter/display block.
package cnt_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] dig_idx_t;

  localparam logic [7:0] LED_RST = 8'hC0;

  // BCD digit to active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cnt_bcd_stage.sv
// One modulo-MOD BCD up/down stage (tens:ones); carry doubles as borrow when counting down.
// Preset load ports exist only when CNT_PRESET_EN is defined.
module cnt_bcd_stage
  import cnt_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       dec,
`ifdef CNT_PRESET_EN
  input  logic       load,
  input  logic [7:0] load_val,
`endif
  output logic [7:0] val,
  output logic       carry
);

  localparam bcd_t MAX_T = bcd_t'((MOD - 1) / 10);
  localparam bcd_t MAX_O = bcd_t'((MOD - 1) % 10);

  bcd_t tens, ones;
  logic at_max, at_zero;

  assign at_max  = (tens == MAX_T) && (ones == MAX_O);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);
  assign carry   = tick && (dec ? at_zero : at_max);
  assign val     = {tens, ones};

`ifdef CNT_PRESET_EN
  // Out-of-range or non-BCD presets collapse to zero.
  logic ld_ok;
  assign ld_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                 ((load_val[7:4] < MAX_T) ||
                  ((load_val[7:4] == MAX_T) && (load_val[3:0] <= MAX_O)));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end
`ifdef CNT_PRESET_EN
    else if (load) begin
      tens <= ld_ok ? load_val[7:4] : 4'd0;
      ones <= ld_ok ? load_val[3:0] : 4'd0;
    end
`endif
    else if (tick) begin
      if (!dec) begin
        if (at_max) begin
          tens <= '0;
          ones <= '0;
        end else if (ones == 4'd9) begin
          ones <= '0;
          tens <= tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens <= MAX_T;
          ones <= MAX_O;
        end else if (ones == 4'd0) begin
          ones <= 4'd9;
          tens <= tens - 4'd1;
        end else begin
          ones <= ones - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cnt_bcd_mmss.sv
// Two-stage BCD up/down counter (HI:LO) with tick prescaler and 4-digit multiplexed LED driver.
// Define CNT_PRESET_EN to enable the LOAD/LOAD_VAL preset path.
module cnt_bcd_mmss
  import cnt_pkg::*;
#(
  parameter int SEC1_MAX = 100_000_000,
  parameter int SCAN_MAX = 100_000,
  parameter int MOD_LO   = 60,
  parameter int MOD_HI   = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        DEC,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VAL,
  output logic [15:0] CNT,
  output logic        WRAP,
  output logic [7:0]  LED,
  output logic [3:0]  SA
);

  localparam int PRE_W  = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
  localparam int SCAN_W = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SEC1_MAX - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_MAX - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  dig_idx_t          idx;
  bcd_t              cur;
  logic              tick, tick_p0, load_p0;
  logic              lo_carry, hi_carry;
  logic [7:0]        lo_val, hi_val;

`ifdef CNT_PRESET_EN
  assign load_p0 = LOAD;
`else
  logic unused_load;
  assign unused_load = ^{LOAD, LOAD_VAL};
  assign load_p0     = 1'b0;
`endif

  // Stage 0: prescaler; a preset wins over a coincident tick.
  assign tick    = EN && (pre_cnt == PRE_LAST);
  assign tick_p0 = tick && !load_p0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                pre_cnt <= '0;
    else if (load_p0 || tick) pre_cnt <= '0;
    else if (EN)              pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Stage 1: BCD count chain and full-chain wrap flag.
  cnt_bcd_stage #(.MOD(MOD_LO)) u_lo (
    .clk(CLK), .rst(RESET), .tick(tick_p0), .dec(DEC),
`ifdef CNT_PRESET_EN
    .load(load_p0), .load_val(LOAD_VAL[7:0]),
`endif
    .val(lo_val), .carry(lo_carry)
  );

  cnt_bcd_stage #(.MOD(MOD_HI)) u_hi (
    .clk(CLK), .rst(RESET), .tick(lo_carry), .dec(DEC),
`ifdef CNT_PRESET_EN
    .load(load_p0), .load_val(LOAD_VAL[15:8]),
`endif
    .val(hi_val), .carry(hi_carry)
  );

  assign CNT = {hi_val, lo_val};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) WRAP <= 1'b0;
    else       WRAP <= hi_carry;
  end

  // Stage 2: digit scan; SA and LED are registered from the same index.
  always_comb begin
    cur = CNT[3:0];
    case (idx)
      2'd0:    cur = CNT[3:0];
      2'd1:    cur = CNT[7:4];
      2'd2:    cur = CNT[11:8];
      default: cur = CNT[15:12];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      idx      <= '0;
      SA       <= 4'b0001;
      LED      <= LED_RST;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      SA  <= 4'b0001 << idx;
      LED <= {idx != 2'd2, seg7(cur)};
    end
  end

endmodule

// File: tb/tb_cnt_bcd_mmss.sv
// Bench for cnt_bcd_mmss: whole-count arithmetic model checked every cycle plus directed literal checks.
module tb_cnt_bcd_mmss;

  localparam int SEC1_MAX = 4;
  localparam int SCAN_MAX = 2;
  localparam int MOD_LO   = 60;
  localparam int MOD_HI   = 60;
  localparam int NTOT     = MOD_LO * MOD_HI;

  logic        clk = 1'b0;
  logic        rst, en, dec, load;
  logic [15:0] load_val;
  logic [15:0] cnt;
  logic        wrap;
  logic [7:0]  led;
  logic [3:0]  sa;

  int checks    = 0;
  int failures  = 0;
  int wrap_seen = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  cnt_bcd_mmss #(.SEC1_MAX(SEC1_MAX), .SCAN_MAX(SCAN_MAX), .MOD_LO(MOD_LO), .MOD_HI(MOD_HI)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .DEC(dec), .LOAD(load), .LOAD_VAL(load_val),
    .CNT(cnt), .WRAP(wrap), .LED(led), .SA(sa)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int total);
    int h, l;
    h = total / MOD_LO;
    l = total % MOD_LO;
    return {4'(h / 10), 4'(h % 10), 4'(l / 10), 4'(l % 10)};
  endfunction

  function automatic int stage_from_bcd(input logic [7:0] b, input int modv);
    int t, o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (t > 9 || o > 9 || t * 10 + o >= modv) return 0;
    return t * 10 + o;
  endfunction

  // Model: the count is one integer 0..NTOT-1; display index derives from edges since reset.
  int         m_total, m_pre, m_cyc;
  logic       m_wrap;
  logic [3:0] m_sa;
  logic [7:0] m_led;

  always @(posedge clk or posedge rst) begin : model
    int idx;
    logic [15:0] c;
    if (rst) begin
      m_total = 0; m_pre = 0; m_cyc = 0; m_wrap = 1'b0;
      m_sa = 4'b0001; m_led = 8'hC0;
    end else begin
      idx   = (m_cyc / SCAN_MAX) % 4;
      c     = to_bcd(m_total);
      m_sa  = 4'b0001 << idx;
      m_led = {idx != 2, seg_tab[c[idx*4 +: 4]]};
      m_cyc++;
      m_wrap = 1'b0;
`ifdef CNT_PRESET_EN
      if (load) begin
        m_total = stage_from_bcd(load_val[15:8], MOD_HI) * MOD_LO + stage_from_bcd(load_val[7:0], MOD_LO);
        m_pre   = 0;
      end else
`endif
      if (en) begin
        if (m_pre == SEC1_MAX - 1) begin
          m_pre = 0;
          if (!dec) begin
            if (m_total == NTOT - 1) begin m_total = 0; m_wrap = 1'b1; end
            else m_total++;
          end else begin
            if (m_total == 0) begin m_total = NTOT - 1; m_wrap = 1'b1; end
            else m_total--;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cnt", 32'(cnt), 32'(to_bcd(m_total)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("sa", 32'(sa), 32'(m_sa));
    check("led", 32'(led), 32'(m_led));
    if (wrap === 1'b1) wrap_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [7:0] led_1234(input logic [3:0] s);
    case (s)
      4'b0001: return 8'h99;
      4'b0010: return 8'hB0;
      4'b0100: return 8'h24;
      4'b1000: return 8'hF9;
      default: return 8'h00;
    endcase
  endfunction

  initial begin : stim
    logic [3:0] sa_seen;
    rst = 1'b1; en = 1'b0; dec = 1'b0; load = 1'b0; load_val = 16'h0000;
    step(3);
    check("rst_cnt", 32'(cnt), 32'h0000);
    check("rst_sa", 32'(sa), 32'h1);
    check("rst_led", 32'(led), 32'hC0);
    check("rst_wrap", 32'(wrap), 32'h0);

    // 60 ticks upward: one full LO wrap into HI.
    rst = 1'b0; en = 1'b1; dec = 1'b0; wrap_seen = 0;
    step(240);
    check("up60_cnt", 32'(cnt), 32'h0100);
    check("up60_model", 32'(to_bcd(m_total)), 32'h0100);
    check("up60_nowrap", 32'(wrap_seen), 32'h0);

    load_val = 16'h5959; load = 1'b1; wrap_seen = 0;
    step(1);
    load = 1'b0;
    step(4);
`ifdef CNT_PRESET_EN
    check("ld5959_wrap_cnt", 32'(cnt), 32'h0000);
    check("ld5959_wrap", 32'(wrap), 32'h1);
    step(1);
    check("ld5959_wrap_once", 32'(wrap_seen), 32'h1);
`else
    check("noload_cnt", 32'(cnt), 32'h0101);
    check("noload_wrap", 32'(wrap_seen), 32'h0);
`endif

    // Down from zero wraps to the top, then EN=0 freezes count and prescaler.
    rst = 1'b1;
    step(1);
    rst = 1'b0; dec = 1'b1; en = 1'b1; wrap_seen = 0;
    step(4);
    check("down_cnt", 32'(cnt), 32'h5959);
    check("down_wrap", 32'(wrap), 32'h1);
    step(2);
    en = 1'b0;
    step(20);
    check("hold_cnt", 32'(cnt), 32'h5959);
    check("hold_wrap_once", 32'(wrap_seen), 32'h1);
    en = 1'b1;
    step(1);
    check("resume_pre_cnt", 32'(cnt), 32'h5959);
    step(1);
    check("resume_tick_cnt", 32'(cnt), 32'h5958);

    // Load arriving in a tick cycle.
    dec = 1'b0;
    step(3);
    load = 1'b1; load_val = 16'h1234;
    step(1);
    load = 1'b0;
`ifdef CNT_PRESET_EN
    check("ld_tick_cnt", 32'(cnt), 32'h1234);
    check("ld_tick_nowrap", 32'(wrap), 32'h0);
    step(4);
    check("ld_next_cnt", 32'(cnt), 32'h1235);
    en = 1'b0; load = 1'b1; load_val = 16'h1234;
    step(1);
    load = 1'b0;
    step(2);
    sa_seen = 4'h0;
    for (int i = 0; i < 8; i++) begin
      check("disp1234_led", 32'(led), 32'(led_1234(sa)));
      sa_seen |= sa;
      step(1);
    end
    check("disp_all_digits", 32'(sa_seen), 32'hF);
    load = 1'b1; load_val = 16'h127A;
    step(1);
    check("ld_bad_lo", 32'(cnt), 32'h1200);
    load_val = 16'h6012;
    step(1);
    load = 1'b0;
    check("ld_bad_hi", 32'(cnt), 32'h0012);
`else
    check("noload_tick_cnt", 32'(cnt), 32'h5959);
    step(4);
    check("noload_wrap_cnt", 32'(cnt), 32'h0000);
    en = 1'b0;
    step(2);
    sa_seen = 4'h0;
    for (int i = 0; i < 8; i++) begin
      check("disp0000_led", 32'(led), (sa == 4'b0100) ? 32'h40 : 32'hC0);
      sa_seen |= sa;
      step(1);
    end
    check("disp_all_digits", 32'(sa_seen), 32'hF);
`endif

    // Asynchronous reset between edges.
    en = 1'b1;
    step(5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_cnt", 32'(cnt), 32'h0000);
    check("async_sa", 32'(sa), 32'h1);
    check("async_led", 32'(led), 32'hC0);
    step(2);
    rst = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
